// File: rtl/mem_system_pipelined.sv
// Unified fetch + load/store memory with a fixed-latency response pipeline and data-port priority.
// Optional counters perf_i_stall/perf_flushed are built only when MEM_PERF_CNT_EN is defined.
module mem_system_pipelined #(
    parameter int NUM_WORDS = 8192,
    parameter int XLEN      = 32,
    parameter int LATENCY   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [XLEN-1:0]   i_req_addr,
    output logic              i_rsp_valid,
    output logic [XLEN-1:0]   i_rsp_data,
    input  logic              i_flush,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [XLEN-1:0]   d_req_addr,
    input  logic [XLEN/8-1:0] d_req_we,
    input  logic [XLEN-1:0]   d_req_wdata,
    output logic              d_rsp_valid,
    output logic [XLEN-1:0]   d_rsp_data,
    output logic              busy,
    output logic [31:0]       perf_i_stall,
    output logic [31:0]       perf_flushed
);
    localparam int ADDR_W = $clog2(NUM_WORDS);
    localparam int NB     = XLEN / 8;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    typedef struct packed {
        logic            valid;
        port_e           port;
        logic [XLEN-1:0] data;
    } stage_t;

    logic [XLEN-1:0]   mem_q [NUM_WORDS];
    logic [ADDR_W-1:0] i_idx;
    logic [ADDR_W-1:0] d_idx;
    logic              i_accept;
    logic              d_accept;
    logic              d_is_store;
    logic [XLEN-1:0]   rd_data;
    stage_t            head;
    stage_t            tail;
    stage_t            pipe_q [LATENCY];
    stage_t            pipe_d [LATENCY];
    logic              unused_addr_bits;

    // Byte offset and the bits above the array depth are dropped, so addresses alias modulo NUM_WORDS.
    assign i_idx = i_req_addr[ADDR_W+1:2];
    assign d_idx = d_req_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{i_req_addr[XLEN-1:ADDR_W+2], i_req_addr[1:0],
                                d_req_addr[XLEN-1:ADDR_W+2], d_req_addr[1:0]};

    assign d_req_ready = 1'b1;
    assign i_req_ready = !d_req_valid && !i_flush;
    assign d_accept    = d_req_valid;
    assign i_accept    = i_req_valid && i_req_ready;
    assign d_is_store  = |d_req_we;

    // NOTE: the array deliberately has no reset; contents survive rst and the block maps onto RAM.
    always_ff @(posedge clk) begin
        if (d_accept) begin
            for (int b = 0; b < NB; b++) begin
                if (d_req_we[b]) begin
                    mem_q[d_idx][b*8 +: 8] <= d_req_wdata[b*8 +: 8];
                end
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path can leave it holding a latch.
    always_comb begin
        rd_data = '0;
        if (d_accept) begin
            if (!d_is_store) begin
                rd_data = mem_q[d_idx];
            end
        end else if (i_accept) begin
            rd_data = mem_q[i_idx];
        end
    end

    always_comb begin
        head       = '0;
        head.valid = d_accept || i_accept;
        head.port  = d_accept ? PORT_D : PORT_I;
        head.data  = rd_data;
    end

    // A flush kills every fetch that would still be in flight after this edge; data entries keep moving.
    always_comb begin
        pipe_d[0] = head;
        for (int s = 1; s < LATENCY; s++) begin
            pipe_d[s] = pipe_q[s-1];
        end
        if (i_flush) begin
            for (int s = 0; s < LATENCY; s++) begin
                if (pipe_d[s].port == PORT_I) begin
                    pipe_d[s].valid = 1'b0;
                end
            end
        end
    end

    // NOTE: non-blocking assignments make each stage capture its neighbour's pre-edge value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < LATENCY; s++) begin
                pipe_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < LATENCY; s++) begin
                pipe_q[s] <= pipe_d[s];
            end
        end
    end

    assign tail        = pipe_q[LATENCY-1];
    assign i_rsp_valid = tail.valid && (tail.port == PORT_I);
    assign d_rsp_valid = tail.valid && (tail.port == PORT_D);
    assign i_rsp_data  = i_rsp_valid ? tail.data : '0;
    assign d_rsp_data  = d_rsp_valid ? tail.data : '0;

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < LATENCY; s++) begin
            busy = busy | pipe_q[s].valid;
        end
    end

`ifdef MEM_PERF_CNT_EN
    logic [2:0]  flush_cnt;
    logic [31:0] stall_q;
    logic [31:0] stall_d;
    logic [31:0] flushed_q;
    logic [31:0] flushed_d;
    logic [32:0] flushed_sum;

    // The last stage is already presenting its response, so only earlier fetch stages count as discarded.
    always_comb begin
        flush_cnt = '0;
        if (i_flush) begin
            for (int s = 0; s < LATENCY - 1; s++) begin
                if (pipe_q[s].valid && (pipe_q[s].port == PORT_I)) begin
                    flush_cnt = flush_cnt + 3'd1;
                end
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (i_req_valid && !i_req_ready && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
        flushed_sum = {1'b0, flushed_q} + {30'd0, flush_cnt};
        flushed_d   = flushed_sum[32] ? '1 : flushed_sum[31:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q   <= '0;
            flushed_q <= '0;
        end else begin
            stall_q   <= stall_d;
            flushed_q <= flushed_d;
        end
    end

    assign perf_i_stall = stall_q;
    assign perf_flushed = flushed_q;
`else
    assign perf_i_stall = '0;
    assign perf_flushed = '0;
`endif

endmodule
